quad_encoder_counter: RTL

QUAD_ENCODER_COUNTER -- requirements
Module: quad_encoder_counter

---
 rtl/quad_encoder_counter.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/quad_encoder_counter.sv
// Quadrature encoder: sync + glitch filter, 4x decode, windowed velocity.
// Define ENC_ERR_DETECT_EN to latch illegal AB jumps on err.
module quad_encoder_counter #(
  parameter int FILT_LEN = 3,
  parameter int WINDOW   = 50000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               encoder_a,
  input  logic               encoder_b,
  input  logic               pos_clear,
  output logic signed [15:0] position,
  output logic signed [15:0] velocity,
  output logic               vel_valid,
  output logic               dir,
  output logic               err
);
  localparam int WW = $clog2(WINDOW);
  localparam int AW = 22;
  localparam logic [WW-1:0] WLAST = WW'(WINDOW - 1);
  localparam logic [3:0] FL = 4'(FILT_LEN);

  // bit 1 = A, bit 0 = B throughout
  logic [1:0] s1_q, s1_d, s2_q, s2_d, sv_q, sv_d;
  logic [1:0] cand_q, cand_d, filt_q, filt_d;
  logic [1:0] fok_q, fok_d, prev_q, prev_d;
  logic [1:0][3:0] run_q, run_d;
  logic pok_q, pok_d, dec_en;
  logic signed [1:0] step, stp;
  logic signed [15:0] pos_q, pos_d, vel_q, vel_d;
  logic signed [AW-1:0] acc_q, acc_d, sum;
  logic [WW-1:0] win_q, win_d;
  logic vv_q, vv_d, dir_q, dir_d;

  always_comb begin
    s1_d   = {encoder_a, encoder_b};
    s2_d   = s1_q;
    sv_d   = {sv_q[0], 1'b1};
    cand_d = cand_q;
    filt_d = filt_q;
    fok_d  = fok_q;
    run_d  = run_q;
    // sv_q[1] marks s2_q as holding a real pin sample
    if (sv_q[1]) begin
      for (int c = 0; c < 2; c++) begin
        cand_d[c] = s2_q[c];
        if (s2_q[c] != cand_q[c]) begin
          run_d[c] = 4'd1;
        end else if (run_q[c] != FL) begin
          run_d[c] = run_q[c] + 4'd1;
        end
        if (run_d[c] == FL) begin
          filt_d[c] = s2_q[c];
          fok_d[c]  = 1'b1;
        end
      end
    end
  end

  always_comb begin
    step = 2'sd0;
    case ({prev_q, filt_q})
      4'b0001, 4'b0111,
      4'b1110, 4'b1000: step = 2'sd1;
      4'b0010, 4'b1011,
      4'b1101, 4'b0100: step = -2'sd1;
      default:          step = 2'sd0;
    endcase
  end

  assign dec_en = pok_q & (&fok_q);
  assign stp    = dec_en ? step : 2'sd0;
  assign sum    = acc_q + AW'(stp);

  always_comb begin
    prev_d = prev_q;
    pok_d  = pok_q;
    if (&fok_q) begin
      prev_d = filt_q;
      pok_d  = 1'b1;
    end
    pos_d = pos_clear ? 16'sd0 : pos_q + 16'(stp);
    dir_d = (stp != 2'sd0) ? ~stp[1] : dir_q;
    vel_d = vel_q;
    vv_d  = 1'b0;
    if (win_q == WLAST) begin
      win_d = '0;
      acc_d = '0;
      vv_d  = 1'b1;
      if (sum > 22'sd32767) begin
        vel_d = 16'sh7fff;
      end else if (sum < -22'sd32768) begin
        vel_d = 16'sh8000;
      end else begin
        vel_d = sum[15:0];
      end
    end else begin
      win_d = win_q + WW'(1);
      acc_d = sum;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q   <= '0;
      s2_q   <= '0;
      sv_q   <= '0;
      cand_q <= '0;
      filt_q <= '0;
      fok_q  <= '0;
      run_q  <= '0;
      prev_q <= '0;
      pok_q  <= 1'b0;
      pos_q  <= '0;
      vel_q  <= '0;
      acc_q  <= '0;
      win_q  <= '0;
      vv_q   <= 1'b0;
      dir_q  <= 1'b0;
    end else begin
      s1_q   <= s1_d;
      s2_q   <= s2_d;
      sv_q   <= sv_d;
      cand_q <= cand_d;
      filt_q <= filt_d;
      fok_q  <= fok_d;
      run_q  <= run_d;
      prev_q <= prev_d;
      pok_q  <= pok_d;
      pos_q  <= pos_d;
      vel_q  <= vel_d;
      acc_q  <= acc_d;
      win_q  <= win_d;
      vv_q   <= vv_d;
      dir_q  <= dir_d;
    end
  end

`ifdef ENC_ERR_DETECT_EN
  logic err_q, err_d, ill;
  assign ill   = dec_en && ((prev_q ^ filt_q) == 2'b11);
  assign err_d = err_q | ill;
  always_ff @(posedge clk) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= err_d;
  end
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  assign position  = pos_q;
  assign velocity  = vel_q;
  assign vel_valid = vv_q;
  assign dir       = dir_q;
endmodule
